// File: rtl/binary_to_bcd_stream_if.sv
// Handshake and result bundle for binary_to_bcd_stream.
// The master side issues requests and the slave side returns BCD results.
interface binary_to_bcd_stream_if #(
   parameter int INPUT_WIDTH    = 16,
   parameter int DECIMAL_DIGITS = 5
);
   logic [INPUT_WIDTH-1:0]      i_Binary;
   logic                        i_Valid;
   logic                        o_Ready;
   logic [DECIMAL_DIGITS*4-1:0] o_BCD;
   logic [DECIMAL_DIGITS-1:0]   o_Blank;
   logic                        o_Sign;
   logic                        o_Overflow;
   logic                        o_DV;

   modport master (
      output i_Binary, i_Valid,
      input  o_Ready, o_BCD, o_Blank, o_Sign, o_Overflow, o_DV
   );

   modport slave (
      input  i_Binary, i_Valid,
      output o_Ready, o_BCD, o_Blank, o_Sign, o_Overflow, o_DV
   );
endinterface

// File: rtl/binary_to_bcd_stream.sv
// Multi-cycle double-dabble binary-to-BCD converter with leading-zero blanking and overflow flag.
// Define BIN2BCD_SIGNED_EN to treat i_Binary as two's complement and report the sign on o_Sign.
module binary_to_bcd_stream #(
   parameter int INPUT_WIDTH    = 16,
   parameter int DECIMAL_DIGITS = 5
) (
   input logic                   i_Clock,
   input logic                   i_Reset,
   binary_to_bcd_stream_if.slave bus
);
   localparam int BcdWidth   = DECIMAL_DIGITS * 4;
   localparam int CountWidth = $clog2(INPUT_WIDTH);
   localparam logic [CountWidth-1:0]     LastCount  = CountWidth'(INPUT_WIDTH - 1);
   localparam logic [DECIMAL_DIGITS-1:0] BlankReset = ~DECIMAL_DIGITS'(1);

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

   state_t                    state;
   logic [INPUT_WIDTH-1:0]    binWork;
   logic [BcdWidth-1:0]       bcdWork;
   logic [BcdWidth-1:0]       bcdAdjusted;
   logic [BcdWidth-1:0]       bcdOut;
   logic [DECIMAL_DIGITS-1:0] blankNext;
   logic [DECIMAL_DIGITS-1:0] blankOut;
   logic [CountWidth-1:0]     loopCount;
   logic                      overflowSticky;
   logic                      signWork;
   logic                      signOut;
   logic                      overflowOut;
   logic                      dvOut;
   logic                      seenNonZero;
   logic                      inNegative;
   logic [INPUT_WIDTH-1:0]    inMagnitude;
   logic                      accept;

   assign accept = bus.i_Valid && (state == IDLE);

   // The negation is taken as an unsigned word so the most negative input still converts.
`ifdef BIN2BCD_SIGNED_EN
   assign inNegative  = bus.i_Binary[INPUT_WIDTH-1];
   assign inMagnitude = inNegative ? (~bus.i_Binary + INPUT_WIDTH'(1)) : bus.i_Binary;
`else
   assign inNegative  = 1'b0;
   assign inMagnitude = bus.i_Binary;
`endif

   // Every digit of five or more gets +3 before the shift, each digit on its own with no carry.
   always_comb begin
      bcdAdjusted = bcdWork;
      for (int k = 0; k < DECIMAL_DIGITS; k++) begin
         if (bcdWork[4*k +: 4] >= 4'd5)
            bcdAdjusted[4*k +: 4] = bcdWork[4*k +: 4] + 4'd3;
      end
   end

   // Scanning from the top digit down, a digit is blank until the first non-zero digit is seen.
   always_comb begin
      blankNext   = '0;
      seenNonZero = 1'b0;
      for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
         seenNonZero  = seenNonZero | (bcdWork[4*k +: 4] != 4'd0);
         blankNext[k] = ~seenNonZero;
      end
      blankNext[0] = 1'b0;
   end

   // Control FSM and datapath: load on accept, one shift per CONVERT cycle, publish in DONE.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state          <= IDLE;
         binWork        <= '0;
         bcdWork        <= '0;
         loopCount      <= '0;
         overflowSticky <= 1'b0;
         signWork       <= 1'b0;
         bcdOut         <= '0;
         blankOut       <= BlankReset;
         signOut        <= 1'b0;
         overflowOut    <= 1'b0;
         dvOut          <= 1'b0;
      end else begin
         dvOut <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  binWork        <= inMagnitude;
                  bcdWork        <= '0;
                  overflowSticky <= 1'b0;
                  signWork       <= inNegative;
                  loopCount      <= '0;
                  state          <= CONVERT;
               end
            end
            CONVERT: begin
               {bcdWork, binWork} <= {bcdAdjusted[BcdWidth-2:0], binWork, 1'b0};
               if (bcdAdjusted[BcdWidth-1])
                  overflowSticky <= 1'b1;
               if (loopCount == LastCount)
                  state <= DONE;
               else
                  loopCount <= loopCount + CountWidth'(1);
            end
            DONE: begin
               bcdOut      <= bcdWork;
               blankOut    <= blankNext;
               signOut     <= signWork;
               overflowOut <= overflowSticky;
               dvOut       <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_Ready    = (state == IDLE);
   assign bus.o_BCD      = bcdOut;
   assign bus.o_Blank    = blankOut;
   assign bus.o_Sign     = signOut;
   assign bus.o_Overflow = overflowOut;
   assign bus.o_DV       = dvOut;
endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// Self-checking bench for binary_to_bcd_stream: a 5-digit and a 4-digit instance against a decimal-arithmetic model.
// Honours BIN2BCD_SIGNED_EN in the model so the same bench covers both builds.
module tb_binary_to_bcd_stream;
   logic clock;
   logic reset;
   int   passCount;
   int   checkCount;

   binary_to_bcd_stream_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) busA ();
   binary_to_bcd_stream_if #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) busB ();

   binary_to_bcd_stream #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(5)) dutA (
      .i_Clock (clock),
      .i_Reset (reset),
      .bus     (busA)
   );

   binary_to_bcd_stream #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) dutB (
      .i_Clock (clock),
      .i_Reset (reset),
      .bus     (busB)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: plain decimal arithmetic on the input's numeric value.
   function automatic void modelConvert(input logic [15:0] value, input int digits,
                                        output logic [19:0] bcd, output logic [4:0] blank,
                                        output logic sign, output logic overflow);
      longint mag;
      longint limit;
      longint rem;
      longint pw;
      sign = 1'b0;
      mag  = longint'(value);
`ifdef BIN2BCD_SIGNED_EN
      if (value[15]) begin
         sign = 1'b1;
         mag  = 65536 - longint'(value);
      end
`endif
      limit = 1;
      for (int i = 0; i < digits; i++) limit = limit * 10;
      overflow = (mag >= limit);
      rem   = mag % limit;
      bcd   = '0;
      blank = '0;
      pw    = 1;
      for (int k = 0; k < digits; k++) begin
         bcd[4*k +: 4] = 4'((rem / pw) % 10);
         blank[k]      = (k > 0) && (rem < pw);
         pw            = pw * 10;
      end
   endfunction

   function automatic logic readyOf(input int sel);
      return (sel == 0) ? busA.o_Ready : busB.o_Ready;
   endfunction

   function automatic logic dvOf(input int sel);
      return (sel == 0) ? busA.o_DV : busB.o_DV;
   endfunction

   function automatic logic [26:0] resultOf(input int sel);
      if (sel == 0)
         return {busA.o_BCD, busA.o_Blank, busA.o_Sign, busA.o_Overflow};
      return {4'h0, busB.o_BCD, 1'b0, busB.o_Blank, busB.o_Sign, busB.o_Overflow};
   endfunction

   // Drives one request on the chosen instance and waits (bounded) for its o_DV pulse.
   task automatic applyStimulus(input int sel, input logic [15:0] value,
                                output logic [26:0] result, output int latency,
                                output logic readyLeak);
      int guard;
      guard = 0;
      while (readyOf(sel) !== 1'b1 && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      if (sel == 0) begin busA.i_Binary = value; busA.i_Valid = 1'b1; end
      else          begin busB.i_Binary = value; busB.i_Valid = 1'b1; end
      @(posedge clock); #1;
      if (sel == 0) begin busA.i_Valid = 1'b0; busA.i_Binary = 16'($urandom); end
      else          begin busB.i_Valid = 1'b0; busB.i_Binary = 16'($urandom); end
      latency   = 0;
      readyLeak = 1'b0;
      while (latency < 40) begin
         @(posedge clock); #1;
         latency++;
         if (dvOf(sel) === 1'b1) break;
         if (readyOf(sel) !== 1'b0) readyLeak = 1'b1;
      end
      result = resultOf(sel);
   endtask

   task automatic test_reset();
      logic [26:0] expA;
      logic [26:0] expB;
      reset = 1'b1;
      busA.i_Valid = 1'b0; busA.i_Binary = '0;
      busB.i_Valid = 1'b0; busB.i_Binary = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      expA = {20'h00000, 5'b11110, 1'b0, 1'b0};
      expB = {20'h00000, 5'b01110, 1'b0, 1'b0};
      checkCount++;
      if ({resultOf(0), busA.o_DV, busA.o_Ready} !== {expA, 1'b0, 1'b1})
         $display("[TB] FAIL reset_A: got %h dv=%b rdy=%b, want %h dv=0 rdy=1", resultOf(0), busA.o_DV, busA.o_Ready, expA);
      else passCount++;
      checkCount++;
      if ({resultOf(1), busB.o_DV, busB.o_Ready} !== {expB, 1'b0, 1'b1})
         $display("[TB] FAIL reset_B: got %h dv=%b rdy=%b, want %h dv=0 rdy=1", resultOf(1), busB.o_DV, busB.o_Ready, expB);
      else passCount++;
   endtask

   task automatic test_known_values();
      logic [15:0] vectors [6];
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      logic [26:0] got; int latency; logic leak;
      vectors = '{16'hFFFF, 16'h0000, 16'h0007, 16'h8000, 16'd10, 16'd9999};
      foreach (vectors[i]) begin
         modelConvert(vectors[i], 5, eBcd, eBlank, eSign, eOvf);
         applyStimulus(0, vectors[i], got, latency, leak);
         checkCount++;
         if (got !== {eBcd, eBlank, eSign, eOvf})
            $display("[TB] FAIL known_%h: got bcd=%h blank=%b sign=%b ovf=%b, want bcd=%h blank=%b sign=%b ovf=%b",
                     vectors[i], got[26:7], got[6:2], got[1], got[0], eBcd, eBlank, eSign, eOvf);
         else passCount++;
         checkCount++;
         if (latency !== 17 || leak !== 1'b0)
            $display("[TB] FAIL latency_%h: got %0d cycles readyLeak=%b, want 17 cycles readyLeak=0", vectors[i], latency, leak);
         else passCount++;
      end
   endtask

   task automatic test_random();
      logic [15:0] value;
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      logic [26:0] got; int latency; logic leak;
      for (int n = 0; n < 16; n++) begin
         value = 16'($urandom);
         modelConvert(value, 5, eBcd, eBlank, eSign, eOvf);
         applyStimulus(0, value, got, latency, leak);
         checkCount++;
         if (got !== {eBcd, eBlank, eSign, eOvf} || latency !== 17)
            $display("[TB] FAIL random_%h: got bcd=%h blank=%b sign=%b ovf=%b lat=%0d, want bcd=%h blank=%b sign=%b ovf=%b lat=17",
                     value, got[26:7], got[6:2], got[1], got[0], latency, eBcd, eBlank, eSign, eOvf);
         else passCount++;
      end
   endtask

   task automatic test_overflow();
      logic [15:0] vectors [8];
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      logic [26:0] got; int latency; logic leak;
      vectors = '{16'd12345, 16'd42, 16'd9999, 16'd10000, 16'($urandom), 16'($urandom), 16'($urandom), 16'd0};
      foreach (vectors[i]) begin
         modelConvert(vectors[i], 4, eBcd, eBlank, eSign, eOvf);
         applyStimulus(1, vectors[i], got, latency, leak);
         checkCount++;
         if (got !== {eBcd, eBlank, eSign, eOvf} || latency !== 17)
            $display("[TB] FAIL overflow_%h: got bcd=%h blank=%b sign=%b ovf=%b lat=%0d, want bcd=%h blank=%b sign=%b ovf=%b lat=17",
                     vectors[i], got[26:7], got[6:2], got[1], got[0], latency, eBcd, eBlank, eSign, eOvf);
         else passCount++;
      end
   endtask

   task automatic test_hold();
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      logic [26:0] got; int latency; logic leak; logic held;
      modelConvert(16'd31415, 5, eBcd, eBlank, eSign, eOvf);
      applyStimulus(0, 16'd31415, got, latency, leak);
      held = 1'b1;
      repeat (6) begin
         @(posedge clock); #1;
         busA.i_Binary = 16'($urandom);
         if (resultOf(0) !== {eBcd, eBlank, eSign, eOvf} || busA.o_DV !== 1'b0) held = 1'b0;
      end
      checkCount++;
      if (held !== 1'b1)
         $display("[TB] FAIL hold: outputs now %h dv=%b, want %h dv=0 while idle", resultOf(0), busA.o_DV, {eBcd, eBlank, eSign, eOvf});
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] pending [$];
      logic [15:0] sampled;
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      int results; int cycles; logic firstEdge; logic badReady;
      results = 0; cycles = 0; firstEdge = 1'b1; badReady = 1'b0;
      busA.i_Binary = 16'($urandom);
      busA.i_Valid  = 1'b1;
      while (results < 5 && cycles < 300) begin
         if (busA.o_Ready === 1'b1) begin
            if (!firstEdge && busA.o_DV !== 1'b1) badReady = 1'b1;
            pending.push_back(busA.i_Binary);
         end
         firstEdge = 1'b0;
         @(posedge clock); #1;
         cycles++;
         busA.i_Binary = 16'($urandom);
         if (busA.o_DV === 1'b1) begin
            results++;
            sampled = (pending.size() > 0) ? pending.pop_front() : 16'h0;
            modelConvert(sampled, 5, eBcd, eBlank, eSign, eOvf);
            checkCount++;
            if (resultOf(0) !== {eBcd, eBlank, eSign, eOvf})
               $display("[TB] FAIL b2b_%0d: got %h, want %h for input %h", results, resultOf(0), {eBcd, eBlank, eSign, eOvf}, sampled);
            else passCount++;
         end
      end
      busA.i_Valid = 1'b0;
      checkCount++;
      if (results !== 5 || badReady !== 1'b0)
         $display("[TB] FAIL b2b_flow: got %0d results badReady=%b, want 5 results badReady=0", results, badReady);
      else passCount++;
   endtask

   task automatic test_reset_abort();
      logic [19:0] eBcd; logic [4:0] eBlank; logic eSign, eOvf;
      logic [26:0] got; int latency; logic leak; logic sawDv; logic readyDropped;
      busA.i_Binary = 16'd54321;
      busA.i_Valid  = 1'b1;
      @(posedge clock); #1;
      busA.i_Valid  = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      busA.i_Valid  = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      busA.i_Valid  = 1'b0;
      checkCount++;
      if ({resultOf(0), busA.o_DV, busA.o_Ready} !== {20'h00000, 5'b11110, 1'b0, 1'b0, 1'b0, 1'b1})
         $display("[TB] FAIL abort_state: got %h dv=%b rdy=%b, want 0000011110_0_0 dv=0 rdy=1", resultOf(0), busA.o_DV, busA.o_Ready);
      else passCount++;
      sawDv = 1'b0; readyDropped = 1'b0;
      repeat (25) begin
         @(posedge clock); #1;
         if (busA.o_DV !== 1'b0) sawDv = 1'b1;
         if (busA.o_Ready !== 1'b1) readyDropped = 1'b1;
      end
      checkCount++;
      if (sawDv !== 1'b0 || readyDropped !== 1'b0)
         $display("[TB] FAIL abort_quiet: got dv seen=%b ready dropped=%b, want both 0", sawDv, readyDropped);
      else passCount++;
      modelConvert(16'd2024, 5, eBcd, eBlank, eSign, eOvf);
      applyStimulus(0, 16'd2024, got, latency, leak);
      checkCount++;
      if (got !== {eBcd, eBlank, eSign, eOvf} || latency !== 17)
         $display("[TB] FAIL abort_recover: got %h lat=%0d, want %h lat=17", got, latency, {eBcd, eBlank, eSign, eOvf});
      else passCount++;
   endtask

   // Test sequence.
   initial begin
      passCount  = 0;
      checkCount = 0;
      $display("[TB] starting binary_to_bcd_stream bench");
      test_reset();
      test_known_values();
      test_random();
      test_overflow();
      test_hold();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
